sdvm_pipe: RTL and testbench

- Pipelined, parametrised signed-digit vector multiplier for the online divider datapath.
- Multiplies a WIDTH-bit borrow-save vector (plus/minus rails) by a signed digit in {-1,0,+1}. The digit is delayed by a programmable online delay, DIGIT_DELAY accepted transfers.
- Registered result sits behind a valid/ready handshake. An iteration counter and a sticky illegal-digit flag are provided for the division controller.

---
 rtl/sdvm_pipe_if.sv | 24 ++
 rtl/sdvm_pipe.sv | 93 +++++++++
 tb/tb_sdvm_pipe.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/sdvm_pipe_if.sv
// Handshake bundle for the signed-digit vector multiplier: operand/digit in, product out.
interface sdvm_pipe_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] vec_in_plus;
    logic [WIDTH-1:0] vec_in_minus;
    logic [1:0]       digit_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] vec_out_plus;
    logic [WIDTH-1:0] vec_out_minus;

    modport master (
        output in_valid, vec_in_plus, vec_in_minus, digit_in, out_ready,
        input  in_ready, out_valid, vec_out_plus, vec_out_minus
    );

    modport slave (
        input  in_valid, vec_in_plus, vec_in_minus, digit_in, out_ready,
        output in_ready, out_valid, vec_out_plus, vec_out_minus
    );
endinterface

// File: rtl/sdvm_pipe.sv
// Borrow-save vector times online-delayed signed digit, single registered output stage
// with valid/ready, saturating transfer counter and sticky illegal-digit flag.
module sdvm_pipe #(
    parameter int DIGIT_DELAY = 1,
    parameter int WIDTH       = 8,
    parameter int CNT_W       = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    sdvm_pipe_if.slave       bus,
    output logic [CNT_W-1:0] iter_cnt,
    output logic             digit_err
);
    logic             accept;
    logic [1:0]       d_app;
    logic             out_valid_q;
    logic [WIDTH-1:0] plus_q, minus_q;
    logic [WIDTH-1:0] prod_plus, prod_minus;

    assign bus.in_ready      = ~out_valid_q | bus.out_ready;
    assign accept            = bus.in_valid & bus.in_ready;
    assign bus.out_valid     = out_valid_q;
    assign bus.vec_out_plus  = plus_q;
    assign bus.vec_out_minus = minus_q;

    generate
        if (DIGIT_DELAY == 0) begin : g_nodly
            assign d_app = bus.digit_in;
        end else begin : g_dly
            logic [DIGIT_DELAY-1:0][1:0] dl;
            logic [DIGIT_DELAY-1:0][1:0] dl_base;

            // start flushes first, so a pair accepted with start sees an empty line
            assign dl_base = start ? '0 : dl;
            assign d_app   = dl_base[DIGIT_DELAY-1];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    dl <= '0;
                end else if (accept) begin
                    dl[0] <= bus.digit_in;
                    for (int k = 1; k < DIGIT_DELAY; k++) dl[k] <= dl_base[k-1];
                end else if (start) begin
                    dl <= '0;
                end
            end
        end
    endgenerate

    always_comb begin
        prod_plus  = '0;
        prod_minus = '0;
        case (d_app)
            2'b10: begin
                prod_plus  = bus.vec_in_plus;
                prod_minus = bus.vec_in_minus;
            end
            2'b01: begin
                prod_plus  = ~bus.vec_in_plus;
                prod_minus = ~bus.vec_in_minus;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            plus_q      <= '0;
            minus_q     <= '0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            plus_q      <= prod_plus;
            minus_q     <= prod_minus;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iter_cnt  <= '0;
            digit_err <= 1'b0;
        end else if (start) begin
            iter_cnt  <= accept ? CNT_W'(1) : '0;
            digit_err <= accept && (d_app == 2'b11);
        end else if (accept) begin
            if (iter_cnt != '1) iter_cnt <= iter_cnt + 1'b1;
            if (d_app == 2'b11) digit_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_sdvm_pipe.sv
// Three multiplier configurations driven in lockstep, each scored against a digit-history model.
module tb_sdvm_pipe;
    localparam int N = 3;

    logic       clk = 1'b0;
    logic       rst_n, start, in_valid, out_ready;
    logic [7:0] vp, vm;
    logic [1:0] dig;

    int checks = 0;
    int errs   = 0;

    always #5 clk = ~clk;

    sdvm_pipe_if #(.WIDTH(8)) bus0 ();
    sdvm_pipe_if #(.WIDTH(8)) bus1 ();
    sdvm_pipe_if #(.WIDTH(8)) bus2 ();

    logic [5:0] cnt0, cnt1;
    logic [2:0] cnt2;
    logic       err0, err1, err2;

    assign bus0.in_valid = in_valid; assign bus0.vec_in_plus = vp; assign bus0.vec_in_minus = vm;
    assign bus0.digit_in = dig;      assign bus0.out_ready = out_ready;
    assign bus1.in_valid = in_valid; assign bus1.vec_in_plus = vp; assign bus1.vec_in_minus = vm;
    assign bus1.digit_in = dig;      assign bus1.out_ready = out_ready;
    assign bus2.in_valid = in_valid; assign bus2.vec_in_plus = vp; assign bus2.vec_in_minus = vm;
    assign bus2.digit_in = dig;      assign bus2.out_ready = out_ready;

    sdvm_pipe #(.DIGIT_DELAY(0), .WIDTH(8), .CNT_W(6)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start), .bus(bus0), .iter_cnt(cnt0), .digit_err(err0));
    sdvm_pipe #(.DIGIT_DELAY(2), .WIDTH(8), .CNT_W(6)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start), .bus(bus1), .iter_cnt(cnt1), .digit_err(err1));
    sdvm_pipe #(.DIGIT_DELAY(1), .WIDTH(8), .CNT_W(3)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start), .bus(bus2), .iter_cnt(cnt2), .digit_err(err2));

    logic       ov [N], ir [N], er [N];
    logic [7:0] op [N], om [N], cn [N];
    assign ov[0] = bus0.out_valid; assign ov[1] = bus1.out_valid; assign ov[2] = bus2.out_valid;
    assign ir[0] = bus0.in_ready;  assign ir[1] = bus1.in_ready;  assign ir[2] = bus2.in_ready;
    assign op[0] = bus0.vec_out_plus;  assign op[1] = bus1.vec_out_plus;  assign op[2] = bus2.vec_out_plus;
    assign om[0] = bus0.vec_out_minus; assign om[1] = bus1.vec_out_minus; assign om[2] = bus2.vec_out_minus;
    assign cn[0] = {2'b00, cnt0}; assign cn[1] = {2'b00, cnt1}; assign cn[2] = {5'b00000, cnt2};
    assign er[0] = err0; assign er[1] = err1; assign er[2] = err2;

    function automatic int dd_of(input int i);
        case (i)
            0: return 0;
            1: return 2;
            default: return 1;
        endcase
    endfunction

    function automatic int cmax_of(input int i);
        return (i == 2) ? 7 : 63;
    endfunction

    task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s[u%0d] t=%0t: got %0h expected %0h", nm, i, $time, act, exp);
        end
    endtask

    // Reference: per config, the digits accepted since start/reset; the applied digit is the
    // one accepted DIGIT_DELAY transfers ago, or zero if the history is not that deep yet.
    logic [1:0]  hist [N][$];
    logic [15:0] sbq  [N][$];
    int          mcnt [N];
    bit          merr [N];
    bit          exp_ov;
    bit          acc;
    logic [1:0]  dap;
    logic [15:0] prod;

    always @(posedge clk) begin
        if (rst_n !== 1'b1) begin
            for (int i = 0; i < N; i++) begin
                hist[i].delete(); sbq[i].delete(); mcnt[i] = 0; merr[i] = 0;
            end
            exp_ov = 0;
        end else begin
            acc = in_valid && (!exp_ov || out_ready);
            for (int i = 0; i < N; i++) begin
                if (start) begin hist[i].delete(); mcnt[i] = 0; merr[i] = 0; end
                if (acc) begin
                    hist[i].push_back(dig);
                    dap = (hist[i].size() > dd_of(i)) ? hist[i][hist[i].size() - 1 - dd_of(i)] : 2'b00;
                    case (dap)
                        2'b10:   prod = {vp, vm};
                        2'b01:   prod = {~vp, ~vm};
                        default: prod = 16'h0000;
                    endcase
                    if (dap == 2'b11) merr[i] = 1;
                    if (mcnt[i] < cmax_of(i)) mcnt[i]++;
                    sbq[i].push_back(prod);
                    if (hist[i].size() > 8) void'(hist[i].pop_front());
                end
            end
            if (acc) exp_ov = 1;
            else if (out_ready) exp_ov = 0;
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            for (int i = 0; i < N; i++) begin
                chk("out_valid", i, 32'(ov[i]), 32'(exp_ov));
                chk("in_ready", i, 32'(ir[i]), 32'(!exp_ov || out_ready));
                chk("iter_cnt", i, 32'(cn[i]), 32'(mcnt[i]));
                chk("digit_err", i, 32'(er[i]), 32'(merr[i]));
                if (ov[i] === 1'b1) begin
                    if (sbq[i].size() == 0) begin
                        checks++; errs++;
                        $display("FAIL product[u%0d] t=%0t: got %0h%0h expected no pending product",
                                 i, $time, op[i], om[i]);
                    end else begin
                        chk("product", i, {16'h0, op[i], om[i]}, {16'h0, sbq[i][0]});
                        if (out_ready) void'(sbq[i].pop_front());
                    end
                end
            end
        end
    end

    task automatic cyc(input logic v, input logic [7:0] p, input logic [7:0] m,
                       input logic [1:0] d, input logic ordy, input logic st);
        in_valid = v; vp = p; vm = m; dig = d; out_ready = ordy; start = st;
        @(posedge clk); #1;
    endtask

    task automatic chk_reset_state(input string nm);
        for (int i = 0; i < N; i++) begin
            chk({nm, "_out_valid"}, i, 32'(ov[i]), 32'd0);
            chk({nm, "_plus"},      i, 32'(op[i]), 32'd0);
            chk({nm, "_minus"},     i, 32'(om[i]), 32'd0);
            chk({nm, "_iter_cnt"},  i, 32'(cn[i]), 32'd0);
            chk({nm, "_digit_err"}, i, 32'(er[i]), 32'd0);
            chk({nm, "_in_ready"},  i, 32'(ir[i]), 32'd1);
        end
    endtask

    task automatic rand_cycles(input int n);
        logic [1:0] d;
        for (int k = 0; k < n; k++) begin
            d = 2'($urandom_range(0, 3));
            if (d == 2'b11 && $urandom_range(0, 3) != 0) d = 2'b10;
            cyc($urandom_range(0, 3) != 0, 8'($urandom), 8'($urandom), d,
                $urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0);
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        vp = '0; vm = '0; dig = '0;
        #3 chk_reset_state("reset");
        @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;

        // sign-digit products with no delay on u0
        cyc(1, 8'hA5, 8'h0F, 2'b10, 1, 0);
        cyc(1, 8'hA5, 8'h0F, 2'b01, 1, 0);
        cyc(1, 8'hA5, 8'h0F, 2'b00, 1, 0);
        cyc(0, 8'h00, 8'h00, 2'b00, 1, 0);

        // start with a pair, then delayed digits on u1
        cyc(1, 8'h11, 8'h00, 2'b10, 1, 1);
        cyc(1, 8'h11, 8'h00, 2'b01, 1, 0);
        cyc(1, 8'h11, 8'h00, 2'b10, 1, 0);
        cyc(1, 8'h11, 8'h00, 2'b10, 1, 0);
        cyc(0, 8'h00, 8'h00, 2'b00, 1, 0);

        // backpressure, then drain and accept together
        cyc(1, 8'h33, 8'h44, 2'b10, 0, 0);
        cyc(1, 8'h55, 8'h66, 2'b01, 0, 0);
        cyc(1, 8'h55, 8'h66, 2'b01, 0, 0);
        cyc(1, 8'h77, 8'h88, 2'b10, 1, 0);
        cyc(0, 8'h00, 8'h00, 2'b00, 1, 0);

        // illegal digit is sticky until start
        cyc(1, 8'hFF, 8'hFF, 2'b11, 1, 0);
        cyc(1, 8'h12, 8'h34, 2'b10, 1, 0);
        cyc(1, 8'h12, 8'h34, 2'b01, 1, 0);
        cyc(1, 8'h12, 8'h34, 2'b10, 1, 0);
        cyc(0, 8'h00, 8'h00, 2'b00, 1, 1);
        cyc(0, 8'h00, 8'h00, 2'b00, 1, 0);

        // saturation of the 3-bit counter
        for (int k = 0; k < 10; k++) cyc(1, 8'(k * 17), 8'(k * 5), 2'b10, 1, 0);
        cyc(0, 8'h00, 8'h00, 2'b00, 1, 0);

        rand_cycles(500);

        // async reset while a product is pending
        cyc(1, 8'h5C, 8'hC5, 2'b10, 0, 0);
        #2 rst_n = 1'b0;
        #1 chk_reset_state("async_reset");
        in_valid = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        for (int k = 0; k < 4; k++) cyc(1, 8'h3C, 8'h0A, 2'b10, 1, 0);

        rand_cycles(300);

        for (int k = 0; k < 4; k++) cyc(0, 8'h00, 8'h00, 2'b00, 1, 0);
        for (int i = 0; i < N; i++) chk("drained", i, 32'(sbq[i].size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
